// File: rtl/spi_apb_sequencer.sv
// Round-robin APB master that runs a fixed divider/ss/tx/ctrl+GO, poll, rx-read
// sequence on the SPI core for NREQ requesters. Optional macro: SPI_SEQ_TIMEOUT_EN.
module spi_apb_sequencer #(
  parameter int NREQ     = 2,
  parameter int POLL_MAX = 1023
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic [NREQ-1:0]     req_i,
  input  logic [NREQ*32-1:0]  req_tx_i,
  input  logic [NREQ*8-1:0]   req_ss_i,
  output logic [NREQ-1:0]     ack_o,
  output logic [NREQ-1:0]     done_o,
  output logic                err_o,
  output logic [31:0]         rx_data_o,
  output logic                busy_o,
  input  logic [15:0]         cfg_divider_i,
  input  logic [13:0]         cfg_ctrl_i,
  output logic [3:0]          m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [4:0]          m_paddr,
  output logic [31:0]         m_pwdata,
  input  logic [31:0]         m_prdata
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [4:0] A_RX   = 5'h00;
  localparam logic [4:0] A_CTRL = 5'h10;
  localparam logic [4:0] A_DIV  = 5'h14;
  localparam logic [4:0] A_SS   = 5'h18;

  typedef enum logic [3:0] {
    IDLE, GRANT, WR_DIV, WR_SS, WR_TX, WR_GO, POLL, POLL_CAP, RD_RX, RX_CAP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic          ph_q, ph_d;            // 0 = APB SETUP, 1 = APB ACCESS
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [31:0]   rx_q, rx_d;
  logic [31:0]   tx_q;
  logic [7:0]    ss_q;
  logic [15:0]   div_q;
  logic [13:0]   ctrl_q;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand_idx;
  int            cand;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [9:0]    cnt_q, cnt_d;
  logic          to_q, to_d;
  assign err_o = to_q && (state_q == DONE);
`else
  logic          unused_poll_max;
  assign unused_poll_max = ^POLL_MAX;
  assign err_o = 1'b0;
`endif

  assign rx_data_o = rx_q;

  // First pending request at or after the pointer, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand     = (int'(ptr_q) + i) % NREQ;
      cand_idx = PW'(cand);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    rx_d      = rx_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    cnt_d     = cnt_q;
    to_d      = to_q;
`endif
    ack_o     = '0;
    done_o    = '0;
    busy_o    = (state_q != IDLE);
    m_psel    = 4'h0;
    m_penable = 1'b0;
    m_pwrite  = 1'b0;
    m_paddr   = 5'h00;
    m_pwdata  = 32'h0;
    case (state_q)
      IDLE: if (win_found) begin
        gnt_d   = win_idx;
        state_d = GRANT;
      end
      GRANT: begin
        ack_o[gnt_q] = 1'b1;
        ph_d         = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
        to_d         = 1'b0;
`endif
        state_d      = WR_DIV;
      end
      WR_DIV: begin
        m_psel = 4'hF; m_penable = ph_q; m_pwrite = 1'b1;
        m_paddr = A_DIV; m_pwdata = {16'b0, div_q};
        ph_d = ~ph_q;
        if (ph_q) state_d = WR_SS;
      end
      WR_SS: begin
        m_psel = 4'hF; m_penable = ph_q; m_pwrite = 1'b1;
        m_paddr = A_SS; m_pwdata = {24'b0, ss_q};
        ph_d = ~ph_q;
        if (ph_q) state_d = WR_TX;
      end
      WR_TX: begin
        m_psel = 4'hF; m_penable = ph_q; m_pwrite = 1'b1;
        m_paddr = A_RX; m_pwdata = tx_q;
        ph_d = ~ph_q;
        if (ph_q) state_d = WR_GO;
      end
      WR_GO: begin
        m_psel = 4'hF; m_penable = ph_q; m_pwrite = 1'b1;
        m_paddr = A_CTRL; m_pwdata = {18'b0, ctrl_q | 14'h0100};
        ph_d = ~ph_q;
`ifdef SPI_SEQ_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (ph_q) state_d = POLL;
      end
      POLL: begin
        m_psel = 4'hF; m_penable = ph_q; m_paddr = A_CTRL;
        ph_d = ~ph_q;
        if (ph_q) state_d = POLL_CAP;
      end
      POLL_CAP: begin
        m_paddr = A_CTRL;
        if (m_prdata[8]) begin
`ifdef SPI_SEQ_TIMEOUT_EN
          cnt_d = cnt_q + 10'd1;
          if (cnt_d == 10'(POLL_MAX)) begin
            to_d    = 1'b1;
            rx_d    = 32'h0;
            state_d = DONE;
          end else begin
            state_d = POLL;
          end
`else
          state_d = POLL;
`endif
        end else begin
          state_d = RD_RX;
        end
      end
      RD_RX: begin
        m_psel = 4'hF; m_penable = ph_q; m_paddr = A_RX;
        ph_d = ~ph_q;
        if (ph_q) state_d = RX_CAP;
      end
      RX_CAP: begin
        m_paddr = A_RX;
        rx_d    = m_prdata;
        state_d = DONE;
      end
      DONE: begin
        done_o[gnt_q] = 1'b1;
        ptr_d         = PW'((int'(gnt_q) + 1) % NREQ);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rx_q    <= 32'h0;
`ifdef SPI_SEQ_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rx_q    <= rx_d;
`ifdef SPI_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Transfer parameters are captured in the ack cycle; requesters may change them afterwards
  always_ff @(posedge pclk) begin
    if (state_q == GRANT) begin
      tx_q   <= req_tx_i[32*int'(gnt_q) +: 32];
      ss_q   <= req_ss_i[8*int'(gnt_q) +: 8];
      div_q  <= cfg_divider_i;
      ctrl_q <= cfg_ctrl_i;
    end
  end

endmodule
